// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory-access stage of a five-stage MIPS pipeline. Holds the
//             EX/MEM pipeline register (with stall and flush), drives the
//             data-memory bus from the registered fields, extends load data,
//             forwards the W-stage result into store data and selects the
//             value handed on to the MEM/WB register.
//  Ports    : clk, reset                 - clock, synchronous active-high reset
//             stall, flush               - pipeline register control
//             e_PC/e_Instr/e_ALUout/e_RTdata/e_WriteReg/e_Tnew - EX values
//             w_WriteReg, w_WD           - W-stage result for store forwarding
//             m_data_rdata               - asynchronous data-memory read word
//             m_PC/m_Instr/m_ALUout/m_WriteReg/m_Tnew - registered fields
//             m_Mout                     - load data, PC+8 or ALU result
//             m_data_addr/m_data_wdata/m_data_byteen - data-memory bus
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] e_PC,
    input  logic [31:0] e_Instr,
    input  logic [31:0] e_ALUout,
    input  logic [31:0] e_RTdata,
    input  logic [4:0]  e_WriteReg,
    input  logic [1:0]  e_Tnew,
    input  logic [4:0]  w_WriteReg,
    input  logic [31:0] w_WD,
    input  logic [31:0] m_data_rdata,
    output logic [31:0] m_PC,
    output logic [31:0] m_Instr,
    output logic [31:0] m_ALUout,
    output logic [31:0] m_Mout,
    output logic [4:0]  m_WriteReg,
    output logic [1:0]  m_Tnew,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen
);

    // Opcode / funct encodings
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_LH    = 6'b100001;
    localparam logic [5:0] c_OP_LHU   = 6'b100101;
    localparam logic [5:0] c_OP_LB    = 6'b100000;
    localparam logic [5:0] c_OP_LBU   = 6'b100100;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_SH    = 6'b101001;
    localparam logic [5:0] c_OP_SB    = 6'b101000;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_FN_JALR  = 6'b001001;

    // ------------------------------------------------------------------
    // EX/MEM pipeline register
    // ------------------------------------------------------------------
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_aluout;
    logic [31:0] r_rtdata;
    logic [4:0]  r_write_reg;
    logic [1:0]  r_tnew;

    // Tnew counts down by one stage but saturates at zero.
    logic [1:0] w_tnew_next;
    assign w_tnew_next = (e_Tnew == 2'd0) ? 2'd0 : (e_Tnew - 2'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= PC_RESET;
            r_instr     <= 32'd0;
            r_aluout    <= 32'd0;
            r_rtdata    <= 32'd0;
            r_write_reg <= 5'd0;
            r_tnew      <= 2'd0;
        end else if (flush) begin
            // Bubble keeps the PC so exception/EPC logic downstream still
            // sees which instruction slot this was.
            r_pc        <= e_PC;
            r_instr     <= 32'd0;
            r_aluout    <= 32'd0;
            r_rtdata    <= 32'd0;
            r_write_reg <= 5'd0;
            r_tnew      <= 2'd0;
        end else if (!stall) begin
            r_pc        <= e_PC;
            r_instr     <= e_Instr;
            r_aluout    <= e_ALUout;
            r_rtdata    <= e_RTdata;
            r_write_reg <= e_WriteReg;
            r_tnew      <= w_tnew_next;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the resident instruction
    // ------------------------------------------------------------------
    logic [5:0] w_opcode;
    logic [4:0] w_rt;
    logic [5:0] w_funct;
    logic [1:0] w_a;

    assign w_opcode = r_instr[31:26];
    assign w_rt     = r_instr[20:16];
    assign w_funct  = r_instr[5:0];
    assign w_a      = r_aluout[1:0];

    logic w_is_load;
    logic w_is_link;

    assign w_is_load = (w_opcode == c_OP_LW)  || (w_opcode == c_OP_LH)  ||
                       (w_opcode == c_OP_LHU) || (w_opcode == c_OP_LB)  ||
                       (w_opcode == c_OP_LBU);
    assign w_is_link = (w_opcode == c_OP_JAL) ||
                       ((w_opcode == c_OP_RTYPE) && (w_funct == c_FN_JALR));

    // ------------------------------------------------------------------
    // Store data: forward W result unless rt is $0
    // ------------------------------------------------------------------
    logic [31:0] w_rt_fwd;
    assign w_rt_fwd = ((w_rt != 5'd0) && (w_WriteReg == w_rt)) ? w_WD : r_rtdata;

    logic [31:0] w_wdata;
    logic [3:0]  w_byteen;

    always_comb begin
        w_wdata  = w_rt_fwd;
        w_byteen = 4'b0000;
        case (w_opcode)
            c_OP_SW: begin
                w_byteen = 4'b1111;
            end
            c_OP_SH: begin
                w_byteen = w_a[1] ? 4'b1100 : 4'b0011;
                w_wdata  = {2{w_rt_fwd[15:0]}};
            end
            c_OP_SB: begin
                w_byteen = 4'b0001 << w_a;
                w_wdata  = {4{w_rt_fwd[7:0]}};
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load extension
    // ------------------------------------------------------------------
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    always_comb begin
        case (w_a)
            2'd0:    w_byte = m_data_rdata[7:0];
            2'd1:    w_byte = m_data_rdata[15:8];
            2'd2:    w_byte = m_data_rdata[23:16];
            default: w_byte = m_data_rdata[31:24];
        endcase
    end

    assign w_half = w_a[1] ? m_data_rdata[31:16] : m_data_rdata[15:0];

    always_comb begin
        w_load_data = m_data_rdata;
        case (w_opcode)
            c_OP_LB:  w_load_data = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_data = {24'd0, w_byte};
            c_OP_LH:  w_load_data = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load_data = {16'd0, w_half};
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------
    logic [31:0] w_mout;

    always_comb begin
        w_mout = r_aluout;
        if (w_is_load) begin
            w_mout = w_load_data;
        end else if (w_is_link) begin
            w_mout = r_pc + 32'd8;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign m_PC          = r_pc;
    assign m_Instr       = r_instr;
    assign m_ALUout      = r_aluout;
    assign m_WriteReg    = r_write_reg;
    assign m_Tnew        = r_tnew;
    assign m_Mout        = w_mout;
    assign m_data_addr   = r_aluout;
    assign m_data_wdata  = w_wdata;
    assign m_data_byteen = w_byteen;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Directed self-checking bench for mem_stage.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] e_PC;
    logic [31:0] e_Instr;
    logic [31:0] e_ALUout;
    logic [31:0] e_RTdata;
    logic [4:0]  e_WriteReg;
    logic [1:0]  e_Tnew;
    logic [4:0]  w_WriteReg;
    logic [31:0] w_WD;
    logic [31:0] m_data_rdata;
    logic [31:0] m_PC;
    logic [31:0] m_Instr;
    logic [31:0] m_ALUout;
    logic [31:0] m_Mout;
    logic [4:0]  m_WriteReg;
    logic [1:0]  m_Tnew;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.PC_RESET(32'h0000_3000)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .e_PC         (e_PC),
        .e_Instr      (e_Instr),
        .e_ALUout     (e_ALUout),
        .e_RTdata     (e_RTdata),
        .e_WriteReg   (e_WriteReg),
        .e_Tnew       (e_Tnew),
        .w_WriteReg   (w_WriteReg),
        .w_WD         (w_WD),
        .m_data_rdata (m_data_rdata),
        .m_PC         (m_PC),
        .m_Instr      (m_Instr),
        .m_ALUout     (m_ALUout),
        .m_Mout       (m_Mout),
        .m_WriteReg   (m_WriteReg),
        .m_Tnew       (m_Tnew),
        .m_data_addr  (m_data_addr),
        .m_data_wdata (m_data_wdata),
        .m_data_byteen(m_data_byteen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [5:0] fn);
        return {op, 5'd0, rt, 10'd0, fn};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [31:0] alu, input logic [31:0] rtd,
                         input logic [4:0] wr, input logic [1:0] tnew);
        e_PC       = pc;
        e_Instr    = instr;
        e_ALUout   = alu;
        e_RTdata   = rtd;
        e_WriteReg = wr;
        e_Tnew     = tnew;
    endtask

    // Advance one edge, then sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stall = 1'b1; flush = 1'b0;
        w_WriteReg = 5'd0; w_WD = 32'h0; m_data_rdata = 32'h0;
        drive(32'h0000_5000, mk(6'b101011, 5'd3, 6'd0), 32'h44, 32'h99, 5'd7, 2'd2);

        // Reset held two cycles with stall asserted
        step(); step();
        check("rst_pc",     m_PC,          32'h0000_3000);
        check("rst_instr",  m_Instr,       32'h0);
        check("rst_byteen", {28'd0, m_data_byteen}, 32'h0);
        check("rst_tnew",   {30'd0, m_Tnew},        32'h0);
        check("rst_mout",   m_Mout,        32'h0);
        check("rst_addr",   m_data_addr,   32'h0);
        check("rst_wdata",  m_data_wdata,  32'h0);
        check("rst_wreg",   {27'd0, m_WriteReg},    32'h0);

        reset = 1'b0; stall = 1'b0;

        // sb at offset 3
        drive(32'h3000, mk(6'b101000, 5'd9, 6'd0), 32'h0000_0003, 32'h1234_56AB, 5'd0, 2'd0);
        step();
        check("sb3_byteen", {28'd0, m_data_byteen}, 32'h8);
        check("sb3_wdata",  m_data_wdata,  32'hABAB_ABAB);
        check("sb3_addr",   m_data_addr,   32'h3);

        // sb at offset 0
        drive(32'h3004, mk(6'b101000, 5'd9, 6'd0), 32'h0000_0010, 32'h1234_56AB, 5'd0, 2'd0);
        step();
        check("sb0_byteen", {28'd0, m_data_byteen}, 32'h1);

        // sh upper half
        drive(32'h3008, mk(6'b101001, 5'd9, 6'd0), 32'h0000_0002, 32'h1234_56AB, 5'd0, 2'd0);
        step();
        check("sh2_byteen", {28'd0, m_data_byteen}, 32'hC);
        check("sh2_wdata",  m_data_wdata,  32'h56AB_56AB);

        // sh misaligned (a[0] ignored) and aligned lower half
        drive(32'h300C, mk(6'b101001, 5'd9, 6'd0), 32'h0000_0003, 32'h1234_56AB, 5'd0, 2'd0);
        step();
        check("sh3_byteen", {28'd0, m_data_byteen}, 32'hC);
        drive(32'h300C, mk(6'b101001, 5'd9, 6'd0), 32'h0000_0000, 32'h1234_56AB, 5'd0, 2'd0);
        step();
        check("sh0_byteen", {28'd0, m_data_byteen}, 32'h3);

        // Loads from rdata 0x80FF_7F01
        m_data_rdata = 32'h80FF_7F01;
        drive(32'h3010, mk(6'b100000, 5'd8, 6'd0), 32'h0000_0002, 32'h0, 5'd8, 2'd2);
        step();
        check("lb2",        m_Mout, 32'hFFFF_FFFF);
        check("lb_byteen",  {28'd0, m_data_byteen}, 32'h0);
        drive(32'h3014, mk(6'b100100, 5'd8, 6'd0), 32'h0000_0003, 32'h0, 5'd8, 2'd2);
        step();
        check("lbu3",       m_Mout, 32'h0000_0080);
        drive(32'h3018, mk(6'b100001, 5'd8, 6'd0), 32'h0000_0002, 32'h0, 5'd8, 2'd2);
        step();
        check("lh2",        m_Mout, 32'hFFFF_80FF);
        drive(32'h301C, mk(6'b100101, 5'd8, 6'd0), 32'h0000_0000, 32'h0, 5'd8, 2'd2);
        step();
        check("lhu0",       m_Mout, 32'h0000_7F01);
        drive(32'h3020, mk(6'b100011, 5'd8, 6'd0), 32'h0000_0001, 32'h0, 5'd8, 2'd2);
        step();
        check("lw1",        m_Mout, 32'h80FF_7F01);
        check("lw_tnew",    {30'd0, m_Tnew}, 32'h1);

        // jal: PC+8, Tnew 2 -> 1
        drive(32'h0000_3010, mk(6'b000011, 5'd0, 6'd0), 32'h0000_1234, 32'h0, 5'd31, 2'd2);
        step();
        check("jal_mout",   m_Mout,  32'h0000_3018);
        check("jal_tnew",   {30'd0, m_Tnew}, 32'h1);
        check("jal_wreg",   {27'd0, m_WriteReg}, 32'd31);

        // addu: ALU result passes, Tnew 0 stays 0
        drive(32'h3024, mk(6'b000000, 5'd2, 6'b100001), 32'h0000_0055, 32'h0, 5'd4, 2'd0);
        step();
        check("alu_mout",   m_Mout,  32'h0000_0055);
        check("tnew0",      {30'd0, m_Tnew}, 32'h0);

        // jalr with PC+8 wrapping; Tnew 3 -> 2
        drive(32'hFFFF_FFFC, mk(6'b000000, 5'd0, 6'b001001), 32'h0, 32'h0, 5'd31, 2'd3);
        step();
        check("jalr_wrap",  m_Mout,  32'h0000_0004);
        check("tnew3",      {30'd0, m_Tnew}, 32'h2);

        // Store forwarding from W
        w_WriteReg = 5'd5; w_WD = 32'hDEAD_BEEF;
        drive(32'h3030, mk(6'b101011, 5'd5, 6'd0), 32'h0000_0101, 32'h1111_1111, 5'd0, 2'd0);
        step();
        check("fwd_wdata",  m_data_wdata, 32'hDEAD_BEEF);
        check("sw_byteen",  {28'd0, m_data_byteen}, 32'hF);
        w_WriteReg = 5'd6;
        #1;
        check("nofwd_wdata", m_data_wdata, 32'h1111_1111);

        // rt=0 never forwards even with w_WriteReg=0
        w_WriteReg = 5'd0;
        drive(32'h3034, mk(6'b101011, 5'd0, 6'd0), 32'h0000_0200, 32'h2222_2222, 5'd0, 2'd0);
        step();
        check("rt0_wdata",  m_data_wdata, 32'h2222_2222);

        // Stall 3 cycles with changing inputs: everything holds
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h7000 + i, mk(6'b100011, 5'd1, 6'd0), 32'h900 + i, 32'h0, 5'd1, 2'd2);
            step();
            check("stall_pc",     m_PC,     32'h3034);
            check("stall_instr",  m_Instr,  mk(6'b101011, 5'd0, 6'd0));
            check("stall_alu",    m_ALUout, 32'h0000_0200);
            check("stall_byteen", {28'd0, m_data_byteen}, 32'hF);
        end

        // Flush wins over stall
        flush = 1'b1;
        drive(32'h0000_3040, mk(6'b101011, 5'd3, 6'd0), 32'h44, 32'h99, 5'd7, 2'd2);
        step();
        check("flush_instr",  m_Instr, 32'h0);
        check("flush_pc",     m_PC,    32'h0000_3040);
        check("flush_byteen", {28'd0, m_data_byteen}, 32'h0);
        check("flush_wreg",   {27'd0, m_WriteReg}, 32'h0);
        check("flush_tnew",   {30'd0, m_Tnew}, 32'h0);
        flush = 1'b0; stall = 1'b0;

        // Load a store, then reset in mid-stall clears it
        drive(32'h3050, mk(6'b101000, 5'd3, 6'd0), 32'h1, 32'h5, 5'd0, 2'd1);
        step();
        check("pre_rst_byteen", {28'd0, m_data_byteen}, 32'h2);
        stall = 1'b1; flush = 1'b1; reset = 1'b1;
        step();
        check("rst_stall_instr", m_Instr, 32'h0);
        check("rst_stall_pc",    m_PC,    32'h0000_3000);
        check("rst_stall_byteen", {28'd0, m_data_byteen}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It sits directly upstream of the MEM/WB register and drives that register's inputs. It holds the EX/MEM pipeline register with stall and flush control. From the registered fields it drives the external data-memory bus (address, aligned write data, byte enables), extends load data, and selects `m_Mout` as load data, PC+8 or the ALU result. It also forwards the W-stage result into store data and produces the M-stage Tnew used by the hazard unit.

## Interface
Parameters:
- `PC_RESET`, default 32'h0000_3000: PC value loaded on reset.

Ports:
- `clk`, input, 1: pipeline clock.
- `reset`, input, 1: synchronous, active-high.
- `stall`, input, 1: when high, the register holds its contents.
- `flush`, input, 1: when high, the register loads a bubble.
- `e_PC`, `e_Instr`, `e_ALUout`, `e_RTdata`, inputs, 32 each: EX-stage values.
- `e_WriteReg`, input, 5: destination register from EX.
- `e_Tnew`, input, 2: EX-stage Tnew.
- `w_WriteReg`, input, 5: W-stage destination register for forwarding.
- `w_WD`, input, 32: W-stage write data for forwarding.
- `m_data_rdata`, input, 32: word read from data memory at `m_data_addr`.
- `m_PC`, `m_Instr`, output, 32 each: registered PC and instruction.
- `m_ALUout`, output, 32: registered ALU result.
- `m_Mout`, output, 32: selected result for MEM/WB.
- `m_WriteReg`, output, 5: registered destination register.
- `m_Tnew`, output, 2: registered M-stage Tnew.
- `m_data_addr`, output, 32: data-memory address; equals `m_ALUout`.
- `m_data_wdata`, output, 32: aligned store data.
- `m_data_byteen`, output, 4: store byte enables.

## Operation
Register update rule, evaluated at each rising edge of `clk`, in priority order:
- `reset`: PC=`PC_RESET`, Instr=0, ALUout=0, RTdata=0, WriteReg=0, Tnew=0.
- else `flush`: same values as reset, except PC loads `e_PC`.
- else `stall`: all fields hold.
- else: load all `e_*` inputs. Tnew loads `e_Tnew==0 ? 0 : e_Tnew-1` (saturating, never wraps to 3).

Decode uses the registered `m_Instr`: opcode [31:26], rt [20:16], funct [5:0].
- Loads: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100.
- Stores: sw 101011, sh 101001, sb 101000.
- jal: opcode 000011.
- jalr: opcode 000000 with funct 001001.

Store-data forwarding:
- rt_fwd = `w_WD` when `w_WriteReg`==rt and rt!=0.
- Otherwise rt_fwd = registered RTdata.

Byte enables and write data, with a = `m_ALUout[1:0]`:
- sw: byteen=4'b1111, wdata=rt_fwd.
- sh: byteen=a[1] ? 4'b1100 : 4'b0011, wdata={2{rt_fwd[15:0]}}.
- sb: byteen=4'b0001<<a, wdata={4{rt_fwd[7:0]}}.
- Non-store: byteen=4'b0000, wdata=rt_fwd.
- Misaligned addresses raise no exception. sw/lw ignore a. sh/lh/lhu ignore a[0].

Load extension from `m_data_rdata`:
- lb/lbu select byte a; lb sign-extends, lbu zero-extends.
- lh/lhu select halfword a[1]; lh sign-extends, lhu zero-extends.
- lw passes the word unchanged.

`m_Mout` select:
- Load instruction: extended load data.
- jal/jalr: `m_PC`+8 (32-bit add, wraps modulo 2^32).
- Otherwise: `m_ALUout`.

## Timing
- Latency is one cycle. EX values presented before edge N appear on `m_*` after edge N.
- Every combinational output settles in the same cycle from the registered fields, `m_data_rdata` and the W inputs.
- Memory read is asynchronous: `m_data_rdata` must be valid in the same cycle as `m_data_addr`.
- Reset values: m_PC=`PC_RESET`, m_Instr=0, m_ALUout=0, m_data_addr=0, m_WriteReg=0, m_Tnew=0, m_data_byteen=0, m_Mout=0, m_data_wdata=0. The last assumes `w_WriteReg`=0; otherwise rt_fwd rules apply.
- `flush` and `stall` both high: the flush wins.
- `reset` together with either control: the reset wins.
- Reset in mid-stall clears the held instruction.
- A bubble (Instr=0) never asserts byteen and writes to $0 only.
- Forwarding from W is combinational. rt=0 never forwards, even if `w_WriteReg`=0.
- A stall holds the register only; byteen stays asserted every cycle a store is held. The hazard unit must not stall M while a store is resident. This block does not gate it.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `stall`=1 -> m_PC=0x00003000, m_Instr=0, byteen=0, m_Tnew=0.
- **Stores:** sb with ALUout=0x0000_0003, rt=0x1234_56AB -> byteen=4'b1000, wdata=0xABABABAB. sh with ALUout=0x2 -> byteen=4'b1100, wdata=0x56AB56AB.
- **Loads:** rdata=0x80FF_7F01.
  - lb with a=2 -> m_Mout=0xFFFFFFFF.
  - lbu with a=3 -> 0x00000080.
  - lh with a=2 -> 0xFFFF80FF.
  - lhu with a=0 -> 0x00007F01.
- **jal:** e_PC=0x00003010 -> m_Mout=0x00003018 one cycle later. e_Tnew=2 -> m_Tnew=1. e_Tnew=0 -> m_Tnew=0.
- **Forwarding:** sw with rt=5 and `w_WriteReg`=5, `w_WD`=0xDEADBEEF -> wdata=0xDEADBEEF. Same with rt=0 and `w_WriteReg`=0 -> wdata=RTdata.
- **Stall/flush:** `stall` for 3 cycles -> fields hold. `flush` with `stall`=1 and e_PC=0x3040 -> m_Instr=0, m_PC=0x3040, byteen=0.
